// File: rtl/add_stream_acc_pkg.sv
// ---------------------------------------------------------------------------
// add_stream_pkg
// Shared definitions for the add_stream_acc block:
//   ADD_WRAP / ADD_SAT : overflow-mode selectors for the SATURATE parameter
//   sum_width()        : width of the internal per-lane sum (operand + 2 bits),
//                        wide enough for a + b + acc without losing the carry
// ---------------------------------------------------------------------------
package add_stream_pkg;

    localparam int ADD_WRAP = 0;
    localparam int ADD_SAT  = 1;

    // Two extra bits hold the worst case (2**W-1) * 3 of a three-term sum.
    function automatic int sum_width(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/add_stream_acc_lane.sv
// ---------------------------------------------------------------------------
// add_stream_lane
// One lane of the streaming adder: computes a + b (+ accumulator), flags
// overflow, optionally clamps, and registers the result. The accumulator
// tracks the registered result so successive accepted beats can chain.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   accept        : beat accepted this cycle (handshake resolved at top)
//   acc_en        : add the accumulator into this beat's sum
//   acc_clear     : zero the accumulator (and ignore it for this beat)
//   a, b          : lane operands
//   result        : registered lane result
//   overflow      : registered flag, true sum exceeded 2**WIDTH-1
// ---------------------------------------------------------------------------
module add_stream_lane
    import add_stream_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = ADD_WRAP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             accept,
    input  logic             acc_en,
    input  logic             acc_clear,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int SUM_W = sum_width(WIDTH);
    localparam int EXT_W = SUM_W - WIDTH;

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] result_r;
    logic             overflow_r;

    logic [SUM_W-1:0] acc_term_s;
    logic [SUM_W-1:0] sum_s;
    logic             overflow_s;
    logic [WIDTH-1:0] result_s;

    // Select the accumulator term; a same-cycle clear makes it read as zero.
    always_comb begin
        acc_term_s = {SUM_W{1'b0}};
        if (acc_en && !acc_clear) begin
            acc_term_s = {{EXT_W{1'b0}}, acc_r};
        end else begin
            acc_term_s = {SUM_W{1'b0}};
        end
    end

    // Widened three-term sum, overflow detection and optional clamp.
    always_comb begin
        sum_s      = {{EXT_W{1'b0}}, a} + {{EXT_W{1'b0}}, b} + acc_term_s;
        overflow_s = |sum_s[SUM_W-1:WIDTH];
        result_s   = sum_s[WIDTH-1:0];
        if ((SATURATE == ADD_SAT) && overflow_s) begin
            result_s = {WIDTH{1'b1}};
        end else begin
            result_s = sum_s[WIDTH-1:0];
        end
    end

    // Result, overflow and accumulator registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_r   <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
            acc_r      <= {WIDTH{1'b0}};
        end else if (accept) begin
            result_r   <= result_s;
            overflow_r <= overflow_s;
            // Accumulator follows the post-wrap/post-clamp output value.
            acc_r      <= result_s;
        end else if (acc_clear) begin
            acc_r      <= {WIDTH{1'b0}};
        end else begin
            acc_r      <= acc_r;
        end
    end

    assign result   = result_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/add_stream_acc.sv
// ---------------------------------------------------------------------------
// add_stream_acc
// Multi-lane registered unsigned adder with valid/ready flow control,
// wrap or saturate arithmetic and a per-lane running accumulator.
// Latency 1, full throughput; a held output beat stalls the input.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready is combinational)
//   in0, in1            : operands, lane k at [k*WIDTH +: WIDTH]
//   acc_en              : add each lane accumulator into the sum (on accept)
//   acc_clear           : clear all lane accumulators
//   out_valid/out_ready : output handshake
//   out                 : registered result, all lanes
//   overflow            : registered per-lane overflow flags
// ---------------------------------------------------------------------------
module add_stream_acc
    import add_stream_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NCHAN    = 2,
    parameter int SATURATE = ADD_WRAP
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCHAN*WIDTH-1:0] in0,
    input  logic [NCHAN*WIDTH-1:0] in1,
    input  logic                   acc_en,
    input  logic                   acc_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCHAN*WIDTH-1:0] out,
    output logic [NCHAN-1:0]       overflow
);

    logic out_valid_r;
    logic in_ready_s;
    logic accept_s;

    // The output register can take a new beat when empty or being drained.
    assign in_ready_s = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;

    // Output-valid register: set on accept, cleared when drained with no refill.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    for (genvar k = 0; k < NCHAN; k++) begin : g_lane
        add_stream_lane #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .accept    (accept_s),
            .acc_en    (acc_en),
            .acc_clear (acc_clear),
            .a         (in0[k*WIDTH +: WIDTH]),
            .b         (in1[k*WIDTH +: WIDTH]),
            .result    (out[k*WIDTH +: WIDTH]),
            .overflow  (overflow[k])
        );
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_add_stream_acc.sv
// ---------------------------------------------------------------------------
// tb_add_stream_acc
// Scoreboard bench: a wrap-mode and a saturate-mode instance share stimulus.
// Accepted beats push hand-computed expectations; a monitor pops and compares
// whenever a beat is transferred on the output.
// ---------------------------------------------------------------------------
module tb_add_stream_acc;

    localparam int WIDTH = 8;
    localparam int NCHAN = 2;
    localparam int DW    = WIDTH * NCHAN;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          out_ready;
    logic          acc_en;
    logic          acc_clear;
    logic [DW-1:0] in0;
    logic [DW-1:0] in1;

    logic          in_ready_w, in_ready_s;
    logic          out_valid_w, out_valid_s;
    logic [DW-1:0] out_w, out_s;
    logic [1:0]    ovf_w, ovf_s;

    typedef struct packed {
        logic [15:0] wrap;
        logic [15:0] sat;
        logic [1:0]  ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   beats_sent    = 0;
    int   beats_seen    = 0;

    always #5 clock = ~clock;

    add_stream_acc #(.WIDTH(WIDTH), .NCHAN(NCHAN), .SATURATE(0)) dut_wrap (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .in0(in0), .in1(in1), .acc_en(acc_en), .acc_clear(acc_clear),
        .out_valid(out_valid_w), .out_ready(out_ready), .out(out_w), .overflow(ovf_w)
    );

    add_stream_acc #(.WIDTH(WIDTH), .NCHAN(NCHAN), .SATURATE(1)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in0(in0), .in1(in1), .acc_en(acc_en), .acc_clear(acc_clear),
        .out_valid(out_valid_s), .out_ready(out_ready), .out(out_s), .overflow(ovf_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a beat transfers at the edge following a negedge with valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid_w && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("beat_without_expectation", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    beats_seen++;
                    check("wrap_out",      32'(out_w),       32'(e.wrap));
                    check("wrap_overflow", 32'(ovf_w),       32'(e.ovf));
                    check("sat_out",       32'(out_s),       32'(e.sat));
                    check("sat_overflow",  32'(ovf_s),       32'(e.ovf));
                    check("sat_valid",     32'(out_valid_s), 32'd1);
                end
            end
        end
    end

    // Present a beat, hold it until accepted, record its expected response.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic ae, input logic ac,
                        input logic [15:0] ew, input logic [15:0] es, input logic [1:0] eo);
        exp_t e;
        logic accepted;
        accepted  = 1'b0;
        in0       = a;
        in1       = b;
        acc_en    = ae;
        acc_clear = ac;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clock);
            if (in_ready_w) begin
                e.wrap = ew;
                e.sat  = es;
                e.ovf  = eo;
                sb_q.push_back(e);
                beats_sent++;
                accepted = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        check("send_accepted", 32'(accepted), 32'd1);
        in_valid  = 1'b0;
        acc_en    = 1'b0;
        acc_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        acc_en    = 1'b0;
        acc_clear = 1'b0;
        in0       = 16'h0000;
        in1       = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("reset_out_valid", 32'(out_valid_w), 32'd0);
        check("reset_out",       32'(out_w),       32'h0000);
        check("reset_overflow",  32'(ovf_w),       32'd0);
        check("reset_in_ready",  32'(in_ready_w),  32'd1);
        @(posedge clock);
        #1;

        // Basic beats, including single-lane overflow
        send(16'h1012, 16'h0234, 1'b0, 1'b0, 16'h1246, 16'h1246, 2'b00);
        send(16'h01F0, 16'h0120, 1'b0, 1'b0, 16'h0210, 16'h02FF, 2'b01);
        // All-ones operands, then accumulate: sum needs the top internal bit
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFEFE, 16'hFFFF, 2'b11);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFCFC, 16'hFFFF, 2'b11);

        // Lane-0 accumulate sequence
        send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 16'h0003, 2'b00);
        send(16'h0003, 16'h0004, 1'b1, 1'b0, 16'h000A, 16'h000A, 2'b00);
        send(16'h0005, 16'h0006, 1'b1, 1'b1, 16'h000B, 16'h000B, 2'b00);
        acc_clear = 1'b1;
        idle(1);
        acc_clear = 1'b0;
        send(16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0002, 16'h0002, 2'b00);

        // Backpressure: hold one beat while the input keeps changing
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 16'h3333, 2'b00);
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in0      = 16'(k * 257);
            in1      = 16'(k * 514);
            in_valid = 1'b1;
            @(negedge clock);
            check("stall_in_ready",  32'(in_ready_w),  32'd0);
            check("stall_out_hold",  32'(out_w),       32'h3333);
            check("stall_out_valid", 32'(out_valid_w), 32'd1);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        send(16'h0404, 16'h0505, 1'b0, 1'b0, 16'h0909, 16'h0909, 2'b00);
        idle(3);

        // Reset while a beat is held
        out_ready = 1'b0;
        send(16'h0A0A, 16'h0B0B, 1'b0, 1'b0, 16'h1515, 16'h1515, 2'b00);
        check("held_before_reset", 32'(sb_q.size()), 32'd1);
        reset    = 1'b1;
        in_valid = 1'b1;
        acc_en   = 1'b1;
        in0      = 16'h5555;
        in1      = 16'h5555;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        acc_en   = 1'b0;
        beats_sent -= sb_q.size();
        sb_q.delete();
        @(negedge clock);
        check("midreset_out_valid", 32'(out_valid_w), 32'd0);
        check("midreset_out",       32'(out_w),       32'h0000);
        check("midreset_in_ready",  32'(in_ready_w),  32'd1);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(16'h0707, 16'h0808, 1'b1, 1'b0, 16'h0F0F, 16'h0F0F, 2'b00);
        idle(4);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("beat_count",       32'(beats_seen),  32'(beats_sent));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
